// File: rtl/dp_arb_pkg.sv
// Shared types and constants for the two-requester datapath arbiter.
// The optional grant-length limit is enabled by defining DP_ARB_TIMEOUT_EN.
package dp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT0    = 2'd1,
        ST_GNT1    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    localparam int unsigned NOP_OPCODE      = 0;
    localparam int          DEFAULT_TIMEOUT = 64;

    // Round-robin pick from IDLE; last_served=1 means requester 0 wins a tie.
    function automatic arb_state_e rr_pick(input logic req0, input logic req1,
                                           input logic last_served);
        arb_state_e pick;
        pick = ST_IDLE;
        if (req0 && (!req1 || last_served))
            pick = ST_GNT0;
        else if (req1)
            pick = ST_GNT1;
        return pick;
    endfunction

endpackage

// File: rtl/dp_arb_mux.sv
// Combinational steering of one requester's datapath controls, selected by the grant.
// With no grant the datapath sees a NOP with all addresses at zero.
module dp_arb_mux
    import dp_arb_pkg::*;
#(
    parameter int size = 3
) (
    input  logic              gnt0_i,
    input  logic              gnt1_i,
    input  logic [size-2:0]   wrt_addr0_i,
    input  logic [size-2:0]   wrt_addr1_i,
    input  logic [size-2:0]   rd_addr1_0_i,
    input  logic [size-2:0]   rd_addr1_1_i,
    input  logic [size-2:0]   rd_addr2_0_i,
    input  logic [size-2:0]   rd_addr2_1_i,
    input  logic              wrt_en0_i,
    input  logic              wrt_en1_i,
    input  logic              load_data0_i,
    input  logic              load_data1_i,
    input  logic [size-1:0]   alu_opcode0_i,
    input  logic [size-1:0]   alu_opcode1_i,
    output logic [size-2:0]   wrt_addr_o,
    output logic [size-2:0]   rd_addr1_o,
    output logic [size-2:0]   rd_addr2_o,
    output logic              wrt_en_o,
    output logic              load_data_o,
    output logic [size-1:0]   alu_opcode_o
);

    always_comb begin
        wrt_addr_o   = '0;
        rd_addr1_o   = '0;
        rd_addr2_o   = '0;
        wrt_en_o     = 1'b0;
        load_data_o  = 1'b0;
        alu_opcode_o = size'(NOP_OPCODE);
        if (gnt0_i) begin
            wrt_addr_o   = wrt_addr0_i;
            rd_addr1_o   = rd_addr1_0_i;
            rd_addr2_o   = rd_addr2_0_i;
            wrt_en_o     = wrt_en0_i;
            load_data_o  = load_data0_i;
            alu_opcode_o = alu_opcode0_i;
        end else if (gnt1_i) begin
            wrt_addr_o   = wrt_addr1_i;
            rd_addr1_o   = rd_addr1_1_i;
            rd_addr2_o   = rd_addr2_1_i;
            wrt_en_o     = wrt_en1_i;
            load_data_o  = load_data1_i;
            alu_opcode_o = alu_opcode1_i;
        end
    end

endmodule

// File: rtl/dp_arbiter.sv
// Round-robin arbiter granting one of two requesters the register-file/ALU datapath.
// Define DP_ARB_TIMEOUT_EN to force release of grants that exceed TIMEOUT cycles.
module dp_arbiter
    import dp_arb_pkg::*;
#(
    parameter int size    = 3,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              Done0,
    input  logic              Done1,
    input  logic [size-2:0]   wrt_addr0,
    input  logic [size-2:0]   wrt_addr1,
    input  logic [size-2:0]   rd_addr1_0,
    input  logic [size-2:0]   rd_addr1_1,
    input  logic [size-2:0]   rd_addr2_0,
    input  logic [size-2:0]   rd_addr2_1,
    input  logic              wrt_en0,
    input  logic              wrt_en1,
    input  logic              load_data0,
    input  logic              load_data1,
    input  logic [size-1:0]   alu_opcode0,
    input  logic [size-1:0]   alu_opcode1,
    output logic [size-2:0]   wrt_addr,
    output logic [size-2:0]   rd_addr1,
    output logic [size-2:0]   rd_addr2,
    output logic              wrt_en,
    output logic              load_data,
    output logic [size-1:0]   alu_opcode,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              Busy,
    output logic              Timeout
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       gnt0_q, gnt1_q, busy_q;
    logic       expire;

`ifdef DP_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;

    assign expire = (cnt_q == CNT_LAST);

    // Grants are only entered from IDLE, so clearing there gives zero on the first granted cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE)
            cnt_d = '0;
        else if (state_q == ST_GNT0 || state_q == ST_GNT1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= ((state_q == ST_GNT0 && Req0 && !Done0) ||
                          (state_q == ST_GNT1 && Req1 && !Done1)) && expire;
        end
    end

    assign Timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign Timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: state_d = rr_pick(Req0, Req1, last_q);
            ST_GNT0: begin
                if (!Req0 || Done0 || expire) begin
                    state_d = ST_RELEASE;
                    last_d  = 1'b0;
                end
            end
            ST_GNT1: begin
                if (!Req1 || Done1 || expire) begin
                    state_d = ST_RELEASE;
                    last_d  = 1'b1;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Grant and busy flags are registered copies of the next state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt0_q  <= (state_d == ST_GNT0);
            gnt1_q  <= (state_d == ST_GNT1);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign Gnt0 = gnt0_q;
    assign Gnt1 = gnt1_q;
    assign Busy = busy_q;

    dp_arb_mux #(
        .size (size)
    ) u_mux (
        .gnt0_i        (gnt0_q),
        .gnt1_i        (gnt1_q),
        .wrt_addr0_i   (wrt_addr0),
        .wrt_addr1_i   (wrt_addr1),
        .rd_addr1_0_i  (rd_addr1_0),
        .rd_addr1_1_i  (rd_addr1_1),
        .rd_addr2_0_i  (rd_addr2_0),
        .rd_addr2_1_i  (rd_addr2_1),
        .wrt_en0_i     (wrt_en0),
        .wrt_en1_i     (wrt_en1),
        .load_data0_i  (load_data0),
        .load_data1_i  (load_data1),
        .alu_opcode0_i (alu_opcode0),
        .alu_opcode1_i (alu_opcode1),
        .wrt_addr_o    (wrt_addr),
        .rd_addr1_o    (rd_addr1),
        .rd_addr2_o    (rd_addr2),
        .wrt_en_o      (wrt_en),
        .load_data_o   (load_data),
        .alu_opcode_o  (alu_opcode)
    );

endmodule

// File: tb/tb_dp_arbiter.sv
// Directed bench for dp_arbiter: reset, single owner, round-robin, isolation, timeout, mid-grant reset.
module tb_dp_arbiter;

    localparam int SZ = 3;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Req0, Req1, Done0, Done1;
    logic [SZ-2:0] wrt_addr0, wrt_addr1, rd_addr1_0, rd_addr1_1, rd_addr2_0, rd_addr2_1;
    logic          wrt_en0, wrt_en1, load_data0, load_data1;
    logic [SZ-1:0] alu_opcode0, alu_opcode1;
    logic [SZ-2:0] wrt_addr, rd_addr1, rd_addr2;
    logic          wrt_en, load_data;
    logic [SZ-1:0] alu_opcode;
    logic          Gnt0, Gnt1, Busy, Timeout;

    int n_total = 0;
    int n_pass  = 0;

    always #5 Clk = ~Clk;

    dp_arbiter #(.size(SZ), .TIMEOUT(4)) dut (
        .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1), .Done0(Done0), .Done1(Done1),
        .wrt_addr0(wrt_addr0), .wrt_addr1(wrt_addr1),
        .rd_addr1_0(rd_addr1_0), .rd_addr1_1(rd_addr1_1),
        .rd_addr2_0(rd_addr2_0), .rd_addr2_1(rd_addr2_1),
        .wrt_en0(wrt_en0), .wrt_en1(wrt_en1),
        .load_data0(load_data0), .load_data1(load_data1),
        .alu_opcode0(alu_opcode0), .alu_opcode1(alu_opcode1),
        .wrt_addr(wrt_addr), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .wrt_en(wrt_en), .load_data(load_data), .alu_opcode(alu_opcode),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .Busy(Busy), .Timeout(Timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        Req0 = 0; Req1 = 0; Done0 = 0; Done1 = 0;
        wrt_addr0 = 0; wrt_addr1 = 0; rd_addr1_0 = 0; rd_addr1_1 = 0;
        rd_addr2_0 = 0; rd_addr2_1 = 0;
        wrt_en0 = 0; wrt_en1 = 0; load_data0 = 0; load_data1 = 0;
        alu_opcode0 = 0; alu_opcode1 = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        Rst = 1;
        tick();
        Rst = 0;
    endtask

    initial begin
        clear_inputs();
        Rst = 1;

        // Reset held two cycles with both requests and write enables active.
        Req0 = 1; Req1 = 1; wrt_en0 = 1; wrt_en1 = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("rst%0d_gnt0", i), Gnt0, 0);
            check($sformatf("rst%0d_gnt1", i), Gnt1, 0);
            check($sformatf("rst%0d_wrt_en", i), wrt_en, 0);
            check($sformatf("rst%0d_busy", i), Busy, 0);
            check($sformatf("rst%0d_timeout", i), Timeout, 0);
        end
        Rst = 0;
        tick();
        check("rst_release_gnt0", Gnt0, 1);
        check("rst_release_gnt1", Gnt1, 0);

        // Single owner: requester 1.
        do_reset();
        check("idle_busy", Busy, 0);
        check("idle_opcode", alu_opcode, 0);
        Req1 = 1; wrt_en1 = 1; wrt_addr1 = 2; alu_opcode1 = 3'b101;
        rd_addr1_1 = 1; rd_addr2_1 = 3; load_data1 = 1;
        tick();
        check("so_c1_gnt1", Gnt1, 1);
        check("so_c1_gnt0", Gnt0, 0);
        check("so_c1_wrt_addr", wrt_addr, 2);
        check("so_c1_opcode", alu_opcode, 5);
        check("so_c1_wrt_en", wrt_en, 1);
        check("so_c1_rd_addr1", rd_addr1, 1);
        check("so_c1_rd_addr2", rd_addr2, 3);
        check("so_c1_load_data", load_data, 1);
        check("so_c1_busy", Busy, 1);
        wrt_addr1 = 1;
        #1;
        check("so_comb_wrt_addr", wrt_addr, 1);
        tick(); tick(); tick();
        Done1 = 1;
        check("so_c4_gnt1", Gnt1, 1);
        tick();
        check("so_c5_gnt1", Gnt1, 0);
        check("so_c5_busy", Busy, 1);
        check("so_c5_wrt_en", wrt_en, 0);
        check("so_c5_wrt_addr", wrt_addr, 0);
        check("so_c5_opcode", alu_opcode, 0);
        check("so_c5_load_data", load_data, 0);
        Req1 = 0; Done1 = 0;
        tick();
        check("so_c6_busy", Busy, 0);
        check("so_c6_gnt1", Gnt1, 0);

        // Round-robin: both requesting, each owner finishes on its third granted cycle.
        do_reset();
        Req0 = 1; Req1 = 1; alu_opcode0 = 3'd1; alu_opcode1 = 3'd6;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr%0d_gnt0", k), Gnt0, (k % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_gnt1", k), Gnt1, (k % 2 == 1) ? 1 : 0);
            check($sformatf("rr%0d_opcode", k), alu_opcode, (k % 2 == 0) ? 1 : 6);
            tick(); tick();
            if (k % 2 == 0) Done0 = 1; else Done1 = 1;
            tick();
            check($sformatf("rr%0d_rel_gnt", k), {30'd0, Gnt1, Gnt0}, 0);
            check($sformatf("rr%0d_rel_busy", k), Busy, 1);
            Done0 = 0; Done1 = 0;
            tick();
            check($sformatf("rr%0d_idle_gnt", k), {30'd0, Gnt1, Gnt0}, 0);
            check($sformatf("rr%0d_idle_busy", k), Busy, 0);
        end

        // Isolation: non-owner's Done and controls are ignored.
        do_reset();
        Req0 = 1; wrt_en0 = 0;
        tick();
        check("iso_gnt0", Gnt0, 1);
        Req1 = 1; Done1 = 1; wrt_en1 = 1;
        #1;
        check("iso_wrt_en_low", wrt_en, 0);
        wrt_en0 = 1;
        #1;
        check("iso_wrt_en_high", wrt_en, 1);
        tick();
        check("iso_gnt0_held", Gnt0, 1);
        check("iso_gnt1_low", Gnt1, 0);

        // Grant length limit (TIMEOUT=4 when enabled).
        do_reset();
        Req0 = 1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("to_c%0d_gnt0", c), Gnt0, 1);
            check($sformatf("to_c%0d_timeout", c), Timeout, 0);
        end
        Req1 = 1;
        tick();
`ifdef DP_ARB_TIMEOUT_EN
        check("to_c5_gnt0", Gnt0, 0);
        check("to_c5_timeout", Timeout, 1);
        tick();
        check("to_c6_timeout", Timeout, 0);
        check("to_c6_busy", Busy, 0);
        tick();
        check("to_c7_gnt1", Gnt1, 1);
        check("to_c7_gnt0", Gnt0, 0);
`else
        check("to_c5_gnt0", Gnt0, 1);
        check("to_c5_timeout", Timeout, 0);
        tick(); tick();
        check("to_c7_gnt0", Gnt0, 1);
        check("to_c7_gnt1", Gnt1, 0);
`endif

        // Reset in the middle of a grant drops it on the next edge.
        do_reset();
        Req1 = 1; wrt_en1 = 1;
        tick();
        check("mr_gnt1_before", Gnt1, 1);
        check("mr_wrt_en_before", wrt_en, 1);
        Rst = 1;
        tick();
        check("mr_gnt1", Gnt1, 0);
        check("mr_wrt_en", wrt_en, 0);
        check("mr_busy", Busy, 0);
        Rst = 0;
        tick();
        check("mr_regrant", Gnt1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
